ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Four-way arbiter that shares the single RAM port among the data and instruction requests of both cores (D0, D1, I0, I1). It sits between the cache layer and the RAM model. It provides round-robin fairness between cores, data-over-instruction priority, and starvation promotion for instruction fetches. Each granted transfer is held until the RAM reports ACCESS.

## Interface
Parameters:
- STARVE_LIMIT, 8: cycles an instruction request may wait before it outranks data requests (min 1).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous reset, active low.
- iREN  in  2  instruction read request, per core.
- dREN  in  2  data read request, per core.
- dWEN  in  2  data write request, per core.
- iaddr  in  2×32 (word_t)  instruction address, per core.
- daddr  in  2×32  data address, per core.
- dstore  in  2×32  write data, per core.
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
- ramload  in  32  RAM read data.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- iwait, dwait  out  2 each  per-core stall.
- iload, dload  out  2×32  read data, per core.
- grant_src  out  arb_src_t  current winner; valid only while grant_valid.
- grant_valid  out  1  a transfer is in flight.

## Operation
- States are IDLE and GRANT.
- IDLE → GRANT occurs when any request is high.
- On that transition the block registers:
  - the winner into grant_src;
  - the request type (write if dWEN);
  - ramaddr_q: daddr for data sources, iaddr for instruction sources;
  - ramstore_q = dstore.
- Winner selection in IDLE, first match wins:
  1. Starved instruction source (counter ≥ STARVE_LIMIT), core rr first.
  2. Data source, core rr first.
  3. Instruction source, core rr first.
- rr is a 1-bit pointer to the favoured core. On completion, rr ← ~(core of the completed source).
- A data source requests when dREN|dWEN. If both are high, the transfer is a write.
- GRANT:
  - Drives ramaddr = ramaddr_q and ramstore = ramstore_q.
  - ramWEN = write; ramREN = ~write.
  - On ramstate == ACCESS: the winner's wait is 0 this cycle. A read returns ramload on the winner's iload/dload. Next state is IDLE.
  - On FREE, BUSY or ERROR: stay in GRANT with strobes held (ERROR is retried).
  - If the winner's request drops before ACCESS: abort. Strobes are 0 from that cycle, next state is IDLE, and rr is not updated.
- Wait outputs (combinational): iwait[c] = iREN[c], dwait[c] = dREN[c]|dWEN[c], except the winner is 0 in its ACCESS cycle.
- Outside ACCESS, iload and dload are 0.
- Starvation counter per core: saturating, width $clog2(STARVE_LIMIT+1).
  - Increments each cycle iREN[c] is high and I[c] is not completing.
  - Clears when iREN[c] is low or I[c] completes.

## Timing
- Reset values:
  - state IDLE; grant_valid 0; grant_src SRC_D0;
  - ramREN/ramWEN 0; ramaddr/ramstore 0; iload/dload 0;
  - rr 0; counters 0.
  - Waits follow requests combinationally, even in reset.
- Minimum latency: request in cycle 0 (IDLE), strobes in cycle 1. If ACCESS arrives in cycle 1, wait drops in cycle 1.
- Back-to-back: after completion there is one IDLE cycle before the next grant. Other requesters see no bubble beyond this.
- Requests arriving during GRANT are not preempted and compete at the next IDLE.
- Reset asserted mid-transfer: strobes drop immediately (asynchronous) and the transfer is abandoned.
- At most one strobe is high in any cycle. ramaddr is stable for the whole of GRANT.

## Structure
- Shared package `arb_pkg` holds:
  - `arb_src_t` enum {SRC_D0, SRC_D1, SRC_I0, SRC_I1};
  - `arb_state_t` {IDLE, GRANT};
  - the default STARVE_LIMIT.
- `word_t` and `ramstate_t` come from cpu_types_pkg.
- Sub-module `starve_counter` (per-core saturating counter with inc/clr, flag ≥ limit) is instantiated twice.

## Test plan
- Reset: nRST=0 with dREN=2'b01 → ramREN=0, dwait=2'b01, grant_valid=0.
- Single read: dREN[0]=1, daddr[0]=0x100, ACCESS after 2 BUSY cycles → ramREN high 3 cycles, ramaddr=0x100, dwait[0]=0 and dload[0]=ramload only in the ACCESS cycle.
- Round robin: dREN=2'b11 held, immediate ACCESS → grants D0, D1, D0, D1 with one IDLE between each.
- Priority and starvation (STARVE_LIMIT=4): iREN[0]=1 with dREN continuously 2'b11 → I0 granted at the IDLE after its counter reaches 4, never later.
- Write precedence: dREN[1]=dWEN[1]=1, daddr[1]=0x200, dstore[1]=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- Abort: grant I1, drop iREN[1] while BUSY → strobes 0 the same cycle, IDLE next cycle, rr unchanged.

Source files
------------

// File: rtl/arb_pkg.sv
// Types shared by the RAM arbiter and its starvation counters.
package arb_pkg;

  // Bit 1 selects instruction vs data, bit 0 is the core index.
  typedef enum logic [1:0] {
    SRC_D0,
    SRC_D1,
    SRC_I0,
    SRC_I1
  } arb_src_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  function automatic arb_src_t mk_src(input logic is_instr, input logic core);
    return arb_src_t'({is_instr, core});
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake status.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter for one core's instruction fetch; flags once it reaches LIMIT.
module starve_counter #(
  parameter int unsigned LIMIT = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LimitW = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < LimitW)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starved = (count_q >= LimitW);

endmodule

// File: rtl/ram_arbiter.sv
// Four-way RAM port arbiter (D0, D1, I0, I1): round-robin between cores, data over
// instruction, with starvation promotion for instruction fetches.
module ram_arbiter
  import cpu_types_pkg::*;
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [1:0]      iREN,
  input  logic [1:0]      dREN,
  input  logic [1:0]      dWEN,
  input  word_t [1:0]     iaddr,
  input  word_t [1:0]     daddr,
  input  word_t [1:0]     dstore,
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  output logic [1:0]      iwait,
  output logic [1:0]      dwait,
  output word_t [1:0]     iload,
  output word_t [1:0]     dload,
  output arb_src_t        grant_src,
  output logic            grant_valid
);

  arb_state_t state_q, state_d;
  arb_src_t   src_q, src_d, win;
  logic       write_q, write_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       rr_q, rr_d;

  logic [1:0] dreq, flag, starved, i_done;
  logic       in_grant, live, done, abort, any_req;

  assign dreq     = dREN | dWEN;
  assign starved  = flag & iREN;
  assign any_req  = |{iREN, dreq};
  assign in_grant = (state_q == GRANT);
  // Winner still asserting its request; dropping it aborts the transfer.
  assign live     = src_q[1] ? iREN[src_q[0]] : dreq[src_q[0]];
  assign done     = in_grant && live && (ramstate == ACCESS);
  assign abort    = in_grant && !live;

  for (genvar c = 0; c < 2; c++) begin : g_starve
    assign i_done[c] = done && src_q[1] && (src_q[0] == 1'(c));

    starve_counter #(
      .LIMIT(STARVE_LIMIT)
    ) u_starve (
      .CLK    (CLK),
      .nRST   (nRST),
      .inc    (iREN[c] && !i_done[c]),
      .clr    (!iREN[c] || i_done[c]),
      .starved(flag[c])
    );
  end

  always_comb begin
    win = SRC_D0;
    if (starved[rr_q])       win = mk_src(1'b1, rr_q);
    else if (starved[~rr_q]) win = mk_src(1'b1, ~rr_q);
    else if (dreq[rr_q])     win = mk_src(1'b0, rr_q);
    else if (dreq[~rr_q])    win = mk_src(1'b0, ~rr_q);
    else if (iREN[rr_q])     win = mk_src(1'b1, rr_q);
    else if (iREN[~rr_q])    win = mk_src(1'b1, ~rr_q);
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    write_d = write_q;
    addr_d  = addr_q;
    store_d = store_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          src_d   = win;
          write_d = !win[1] && dWEN[win[0]];
          addr_d  = win[1] ? iaddr[win[0]] : daddr[win[0]];
          store_d = dstore[win[0]];
        end
      end
      GRANT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          rr_d    = ~src_q[0];
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      src_q   <= SRC_D0;
      write_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    iwait = iREN;
    dwait = dreq;
    iload = '0;
    dload = '0;
    if (done) begin
      if (src_q[1]) begin
        iwait[src_q[0]] = 1'b0;
        if (!write_q) iload[src_q[0]] = ramload;
      end else begin
        dwait[src_q[0]] = 1'b0;
        if (!write_q) dload[src_q[0]] = ramload;
      end
    end
  end

  assign ramREN      = in_grant && live && !write_q;
  assign ramWEN      = in_grant && live && write_q;
  assign ramaddr     = addr_q;
  assign ramstore    = store_q;
  assign grant_src   = src_q;
  assign grant_valid = in_grant;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (STARVE_LIMIT = 4).
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  import arb_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  word_t [1:0] iaddr, daddr, dstore;
  ramstate_t   ramstate;
  word_t       ramload;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore;
  logic [1:0]  iwait, dwait;
  word_t [1:0] iload, dload;
  arb_src_t    grant_src;
  logic        grant_valid;

  int checks;
  int errors;

  ram_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .iREN       (iREN),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .iaddr      (iaddr),
    .daddr      (daddr),
    .dstore     (dstore),
    .ramstate   (ramstate),
    .ramload    (ramload),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .iwait      (iwait),
    .dwait      (dwait),
    .iload      (iload),
    .dload      (dload),
    .grant_src  (grant_src),
    .grant_valid(grant_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramstate = FREE;
    ramload  = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    clear_inputs();

    // Reset: waits follow requests, strobes idle
    dREN = 2'b01;
    #3;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_gv", 32'(grant_valid), 32'd0);
    check("rst_src", 32'(grant_src), 32'(SRC_D0));
    check("rst_ramaddr", ramaddr, 32'd0);
    cyc();
    check("rst_hold_ramREN", 32'(ramREN), 32'd0);

    // Single read, ACCESS after two BUSY cycles
    do_reset();
    dREN = 2'b01; daddr[0] = 32'h100; ramstate = BUSY;
    #1;
    check("rd_c0_gv", 32'(grant_valid), 32'd0);
    check("rd_c0_ren", 32'(ramREN), 32'd0);
    cyc();
    check("rd_c1_ren", 32'(ramREN), 32'd1);
    check("rd_c1_addr", ramaddr, 32'h100);
    check("rd_c1_dwait", 32'(dwait), 32'd1);
    check("rd_c1_dload", dload[0], 32'd0);
    check("rd_c1_src", 32'(grant_src), 32'(SRC_D0));
    cyc();
    check("rd_c2_ren", 32'(ramREN), 32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    #1;
    check("rd_c3_ren", 32'(ramREN), 32'd1);
    check("rd_c3_dwait", 32'(dwait), 32'd0);
    check("rd_c3_dload0", dload[0], 32'hCAFE0001);
    check("rd_c3_dload1", dload[1], 32'd0);
    cyc();
    dREN = 2'b00; ramstate = FREE;
    #1;
    check("rd_c4_gv", 32'(grant_valid), 32'd0);
    check("rd_c4_ren", 32'(ramREN), 32'd0);
    check("rd_c4_dload", dload[0], 32'd0);

    // Round robin between two data requesters
    do_reset();
    dREN = 2'b11; ramstate = ACCESS; ramload = 32'h5555AAAA;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_idle_gv", 32'(grant_valid), 32'd0);
      check("rr_idle_dwait", 32'(dwait), 32'd3);
      cyc();
      check("rr_src", 32'(grant_src), (k % 2 == 0) ? 32'(SRC_D0) : 32'(SRC_D1));
      check("rr_gv", 32'(grant_valid), 32'd1);
      check("rr_dwait", 32'(dwait), (k % 2 == 0) ? 32'd2 : 32'd1);
      cyc();
    end

    // Starvation promotion: I0 wins once its counter reaches 4
    do_reset();
    dREN = 2'b11; iREN = 2'b01; iaddr[0] = 32'h400; ramstate = ACCESS;
    ramload = 32'h12345678;
    cyc();
    check("stv_c1_src", 32'(grant_src), 32'(SRC_D0));
    check("stv_c1_iwait", 32'(iwait), 32'd1);
    cyc();
    cyc();
    check("stv_c3_src", 32'(grant_src), 32'(SRC_D1));
    cyc();
    cyc();
    check("stv_c5_src", 32'(grant_src), 32'(SRC_I0));
    check("stv_c5_addr", ramaddr, 32'h400);
    check("stv_c5_iwait", 32'(iwait), 32'd0);
    check("stv_c5_iload", iload[0], 32'h12345678);
    check("stv_c5_dload", dload[0], 32'd0);
    check("stv_c5_dwait", 32'(dwait), 32'd3);
    cyc();
    iREN = 2'b00;
    cyc();
    check("stv_c7_src", 32'(grant_src), 32'(SRC_D1));

    // Write precedence over read on the same core
    do_reset();
    dREN = 2'b10; dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hDEADBEEF;
    ramstate = BUSY;
    cyc();
    check("wr_wen", 32'(ramWEN), 32'd1);
    check("wr_ren", 32'(ramREN), 32'd0);
    check("wr_store", ramstore, 32'hDEADBEEF);
    check("wr_addr", ramaddr, 32'h200);
    check("wr_src", 32'(grant_src), 32'(SRC_D1));
    cyc();
    ramstate = ACCESS; ramload = 32'hFFFF0000;
    #1;
    check("wr_acc_dwait", 32'(dwait), 32'd0);
    check("wr_acc_dload", dload[1], 32'd0);
    check("wr_acc_wen", 32'(ramWEN), 32'd1);
    cyc();
    dWEN = 2'b00; dREN = 2'b01; daddr[0] = 32'h40; ramstate = BUSY;
    #1;
    check("wr_idle_gv", 32'(grant_valid), 32'd0);
    cyc();
    check("arst_pre_ren", 32'(ramREN), 32'd1);
    check("arst_pre_src", 32'(grant_src), 32'(SRC_D0));
    // Asynchronous reset mid-transfer
    nRST = 1'b0;
    #1;
    check("arst_ren", 32'(ramREN), 32'd0);
    check("arst_gv", 32'(grant_valid), 32'd0);

    // Abort: I1 drops its request while BUSY, rr must stay where D0 left it
    do_reset();
    dREN = 2'b01; ramstate = ACCESS;
    cyc();
    check("ab_d0_src", 32'(grant_src), 32'(SRC_D0));
    cyc();
    dREN = 2'b00; iREN = 2'b10; iaddr[1] = 32'h300; ramstate = BUSY;
    cyc();
    check("ab_i1_src", 32'(grant_src), 32'(SRC_I1));
    check("ab_i1_ren", 32'(ramREN), 32'd1);
    check("ab_i1_addr", ramaddr, 32'h300);
    cyc();
    iREN = 2'b00;
    #1;
    check("ab_drop_ren", 32'(ramREN), 32'd0);
    check("ab_drop_wen", 32'(ramWEN), 32'd0);
    check("ab_drop_gv", 32'(grant_valid), 32'd1);
    cyc();
    dREN = 2'b11; ramstate = ACCESS;
    #1;
    check("ab_idle_gv", 32'(grant_valid), 32'd0);
    cyc();
    check("ab_rr_src", 32'(grant_src), 32'(SRC_D1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
